// File: rtl/sign_mag_to_twos_if.sv
// sign_mag_to_twos_if: start/operand request and result/status bus for the serial converter
interface sign_mag_to_twos_if #(parameter int WIDTH = 6);
  logic start;
  logic sign;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] value;
  logic busy;
  logic done;
  logic overflow;
  modport master (output start, sign, mag, input value, busy, done, overflow);
  modport slave (input start, sign, mag, output value, busy, done, overflow);
endinterface

// File: rtl/sign_mag_to_twos.sv
// sign_mag_to_twos: bit-serial LSB-first sign-magnitude to two's-complement converter
module sign_mag_to_twos #(parameter int WIDTH = 6) (
  input logic clk,
  input logic reset,
  sign_mag_to_twos_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, next;
  logic sign_r, seen_one, ovf_p, ovf_r, ovf_c, out_bit, last;
  logic [WIDTH-1:0] mag_r, sr, sr_next, value_r;
  logic [CW-1:0] cnt;
  // negation = copy bits up to and including the first 1, then invert the rest
  always_comb begin
    out_bit = (sign_r & seen_one) ? ~mag_r[0] : mag_r[0];
    sr_next = {out_bit, sr[WIDTH-1:1]};
    last = cnt == CW'(WIDTH - 1);
    ovf_c = bus.sign ? (bus.mag[WIDTH-1] & |bus.mag[WIDTH-2:0]) : bus.mag[WIDTH-1];
    next = state == IDLE ? (bus.start ? SHIFT : IDLE) :
           state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sign_r <= 1'b0;
      mag_r <= '0;
      seen_one <= 1'b0;
      cnt <= '0;
      sr <= '0;
      value_r <= '0;
      ovf_p <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && bus.start) begin
        sign_r <= bus.sign;
        mag_r <= bus.mag;
        ovf_p <= ovf_c;
        seen_one <= 1'b0;
        cnt <= '0;
      end
      if (state == SHIFT) begin
        mag_r <= mag_r >> 1;
        sr <= sr_next;
        seen_one <= seen_one | (sign_r & mag_r[0]);
        cnt <= cnt + CW'(1);
        if (last) begin
          value_r <= sr_next;
          ovf_r <= ovf_p;
        end
      end
    end
  end
  assign bus.value = value_r;
  assign bus.overflow = ovf_r;
  assign bus.busy = state == SHIFT;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_sign_mag_to_twos.sv
// tb_sign_mag_to_twos: directed vectors with hand-computed two's-complement results
module tb_sign_mag_to_twos;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [5:0] last_val = '0;
  logic last_ovf = 1'b0;
  sign_mag_to_twos_if #(.WIDTH(6)) bus ();
  sign_mag_to_twos #(.WIDTH(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic convert(input logic s, input logic [5:0] m, input logic [5:0] ev, input logic eo);
    bus.start = 1'b1;
    bus.sign = s;
    bus.mag = m;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sign = ~s;
    bus.mag = ~m;
    for (int i = 0; i < 6; i++) begin
      chk("busy_shift", 32'(bus.busy), 32'd1);
      chk("done_shift", 32'(bus.done), 32'd0);
      chk("value_held", 32'(bus.value), 32'(last_val));
      chk("ovf_held", 32'(bus.overflow), 32'(last_ovf));
      @(negedge clk);
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("value", 32'(bus.value), 32'(ev));
    chk("overflow", 32'(bus.overflow), 32'(eo));
    @(negedge clk);
    chk("done_low", 32'(bus.done), 32'd0);
    chk("value_kept", 32'(bus.value), 32'(ev));
    last_val = ev;
    last_ovf = eo;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.sign = 1'b0;
    bus.mag = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_value", 32'(bus.value), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    convert(1'b0, 6'd9, 6'b001001, 1'b0);
    convert(1'b1, 6'd21, 6'b101011, 1'b0);
    convert(1'b1, 6'd1, 6'b111111, 1'b0);
    convert(1'b1, 6'd32, 6'b100000, 1'b0);
    convert(1'b0, 6'd32, 6'b100000, 1'b1);
    convert(1'b1, 6'd33, 6'b011111, 1'b1);
    convert(1'b1, 6'd0, 6'b000000, 1'b0);
    convert(1'b1, 6'd63, 6'b000001, 1'b1);
    convert(1'b0, 6'd31, 6'b011111, 1'b0);
    // start held high; operands change mid-SHIFT and must not be picked up
    bus.start = 1'b1;
    bus.sign = 1'b0;
    bus.mag = 6'd9;
    @(negedge clk);
    bus.sign = 1'b1;
    bus.mag = 6'd21;
    repeat (5) @(negedge clk);
    chk("hold_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("hold_done1", 32'(bus.done), 32'd1);
    chk("hold_value1", 32'(bus.value), 32'(6'b001001));
    @(negedge clk);
    chk("hold_idle", 32'(bus.done | bus.busy), 32'd0);
    @(negedge clk);
    chk("hold_recapture", 32'(bus.busy), 32'd1);
    repeat (5) @(negedge clk);
    chk("hold_no_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("hold_done2", 32'(bus.done), 32'd1);
    chk("hold_value2", 32'(bus.value), 32'(6'b101011));
    bus.start = 1'b0;
    @(negedge clk);
    chk("hold_done_low", 32'(bus.done), 32'd0);
    last_val = 6'b101011;
    last_ovf = 1'b0;
    convert(1'b0, 6'd40, 6'b101000, 1'b1);
    // abort mid-conversion: reset sampled on the third SHIFT edge
    bus.start = 1'b1;
    bus.sign = 1'b1;
    bus.mag = 6'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_value", 32'(bus.value), 32'd0);
    chk("abort_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done | bus.busy), 32'd0);
    end
    last_val = '0;
    last_ovf = 1'b0;
    convert(1'b1, 6'd5, 6'b111011, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
